// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG sampler: FSM states, cell control
// encodings and default parameter values.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RST    = 2'd1,
    RUN    = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  // {T, I1, I2} toward osc_cell
  localparam logic [2:0] CTRL_RST = 3'b000;
  localparam logic [2:0] CTRL_OSC = 3'b110;

  localparam int WORD_W_DEF  = 32;
  localparam int RST_CYC_DEF = 8;
  localparam int ACC_CYC_DEF = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cell controls that go with a given state; RUN and SAMPLE both oscillate.
  function automatic logic [2:0] ctrl_of(input state_t s);
    return ((s == RUN) || (s == SAMPLE)) ? CTRL_OSC : CTRL_RST;
  endfunction

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchronizer for the asynchronous oscillator output.
module trng_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] ff;

  // Shift the async input through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= 2'b00;
    else        ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/trng_sampler.sv
// TRNG sampler: drives osc_cell through reset/free-run/sample, captures one
// raw bit per cycle, packs bits into words behind a valid/ready output.
// Optional von Neumann debiasing is enabled with `define TRNG_VN_DEBIAS_EN.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int ACC_CYC = ACC_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              osc_in,
  output logic              osc_t,
  output logic              osc_i1,
  output logic              osc_i2,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready
);

  localparam int CNT_W  = $clog2(max2(RST_CYC, ACC_CYC) + 1);
  localparam int BCNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  RST_LD = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]  ACC_LD = CNT_W'(ACC_CYC - 1);
  localparam logic [BCNT_W-1:0] FULL   = BCNT_W'(WORD_W);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         ctrl;
  logic               raw;
  logic               sample;
  logic               bit_vld, bit_val;
  logic [WORD_W-1:0]  shreg;
  logic [BCNT_W-1:0]  bcnt;
  logic               load, room;

  trng_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (osc_in),
    .q     (raw)
  );

  // A full word leaves the packer when the output register is empty or
  // draining this cycle. The FSM only starts a new bit when the packer will
  // have space for it, so no sampled bit is ever dropped.
  assign load   = (bcnt == FULL) && (!rnd_valid || rnd_ready);
  assign room   = (bcnt != FULL) || load;
  assign sample = (state == SAMPLE) && en;

  // State, shared cycle counter and registered cell controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ctrl  <= CTRL_RST;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ctrl  <= ctrl_of(state_nxt);
    end
  end

  // Next state; the counter is reloaded on every entry into RST or RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RST;
          cnt_nxt   = RST_LD;
        end
      end
      RST: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (room) begin
          state_nxt = RUN;
          cnt_nxt   = ACC_LD;
        end
      end
      RUN: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end
      end
      SAMPLE: begin
        state_nxt = RST;
        cnt_nxt   = RST_LD;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  assign osc_t  = ctrl[2];
  assign osc_i1 = ctrl[1];
  assign osc_i2 = ctrl[0];

`ifdef TRNG_VN_DEBIAS_EN
  logic vn_have, vn_first;

  // Hold the first raw bit of each pair until its partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_have  <= 1'b0;
      vn_first <= 1'b0;
    end else if (!en) begin
      vn_have  <= 1'b0;
      vn_first <= 1'b0;
    end else if (sample) begin
      if (!vn_have) begin
        vn_have  <= 1'b1;
        vn_first <= raw;
      end else begin
        vn_have  <= 1'b0;
      end
    end
  end

  // 10 -> 1, 01 -> 0: the emitted bit equals the first bit of a differing pair.
  assign bit_vld = sample && vn_have && (vn_first != raw);
  assign bit_val = vn_first;
`else
  assign bit_vld = sample;
  assign bit_val = raw;
`endif

  // Packer: oldest bit ends up at the MSB; disabling throws away the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (!en) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (bit_vld) begin
      shreg <= {shreg[WORD_W-2:0], bit_val};
      bcnt  <= bcnt + 1'b1;
    end else if (load) begin
      bcnt  <= '0;
    end
  end

  // Output holding register; a load during an accept keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
    end else if (load) begin
      rnd_data  <= shreg;
      rnd_valid <= 1'b1;
    end else if (rnd_ready) begin
      rnd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler with WORD_W=8, RST_CYC=2, ACC_CYC=4
// (7-cycle raw-bit period). Build with TRNG_VN_DEBIAS_EN to exercise debiasing.
module tb_trng_sampler;

  localparam int WORD_W  = 8;
  localparam int RST_CYC = 2;
  localparam int ACC_CYC = 4;
  localparam int PER     = RST_CYC + ACC_CYC + 1;

  logic              clk = 1'b0;
  logic              rst_n, en, osc_in, rnd_ready;
  logic              osc_t, osc_i1, osc_i2, rnd_valid;
  logic [WORD_W-1:0] rnd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trng_sampler #(
    .WORD_W  (WORD_W),
    .RST_CYC (RST_CYC),
    .ACC_CYC (ACC_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .osc_in    (osc_in),
    .osc_t     (osc_t),
    .osc_i1    (osc_i1),
    .osc_i2    (osc_i2),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; osc_in = 1'b0; rnd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl",  32'({osc_t, osc_i1, osc_i2}), 32'h0);
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data",  32'(rnd_data), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present bits v[n-1]..v[0], one per raw-bit period; optionally check controls.
  task automatic feed(input logic [7:0] v, input int n, input bit cc);
    for (int i = n - 1; i >= 0; i--) begin
      osc_in = v[i];
      for (int c = 0; c < PER; c++) begin
        @(negedge clk);
        if (cc) chk("ctrl_seq", 32'({osc_t, osc_i1, osc_i2}), (c < RST_CYC) ? 32'h0 : 32'h6);
      end
    end
  endtask

  // Align to the start of a raw-bit period (falling osc_t), bounded.
  task automatic sync_rst();
    bit   seen = 1'b0;
    logic prev = osc_t;
    for (int k = 0; k < 4 * PER && !seen; k++) begin
      @(negedge clk);
      if (prev && !osc_t) seen = 1'b1;
      prev = osc_t;
    end
    chk("sync_rst", 32'(seen), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
`ifdef TRNG_VN_DEBIAS_EN
    // pairs 10,01,11,00 x4 -> 1,0 x4 -> 8'hAA
    en = 1'b1;
    feed(8'h9C, 8, 1'b1);
    for (int r = 0; r < 3; r++) feed(8'h9C, 8, 1'b0);
    repeat (2) @(negedge clk);
    chk("vn_valid", 32'(rnd_valid), 32'h1);
    chk("vn_data",  32'(rnd_data), 32'hAA);
`else
    // control sequence and raw packing 1,0,1,1,0,0,0,1 -> 8'hB1
    en = 1'b1;
    feed(8'hB1, 8, 1'b1);
    @(negedge clk);
    chk("pack_valid_early", 32'(rnd_valid), 32'h0);
    @(negedge clk);
    chk("pack_valid", 32'(rnd_valid), 32'h1);
    chk("pack_data",  32'(rnd_data), 32'hB1);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    chk("pre_rst_run", 32'(osc_t), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_t",     32'(osc_t), 32'h0);
    chk("arst_i1",    32'(osc_i1), 32'h0);
    chk("arst_valid", 32'(rnd_valid), 32'h0);
    chk("arst_data",  32'(rnd_data), 32'h0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ctrl", 32'({osc_t, osc_i1, osc_i2}), 32'h0);
    end

    // back-pressure: 5A pending, C3 full in packer -> stall in RST
    do_reset();
    en = 1'b1;
    feed(8'h5A, 8, 1'b0);
    feed(8'hC3, 8, 1'b0);
    osc_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("stall_t",     32'(osc_t), 32'h0);
    chk("stall_valid", 32'(rnd_valid), 32'h1);
    chk("stall_data",  32'(rnd_data), 32'h5A);
    rnd_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid", 32'(rnd_valid), 32'h1);
    chk("bp_data",  32'(rnd_data), 32'hC3);
    @(negedge clk);
    chk("bp_drain", 32'(rnd_valid), 32'h0);
    rnd_ready = 1'b0;
    // first bit after the stall sees osc_in=1; remaining 7 bits make 8'hA5
    sync_rst();
    feed(8'h25, 7, 1'b0);
    chk("bp_next_early", 32'(rnd_valid), 32'h0);
    @(negedge clk);
    chk("bp_next_valid", 32'(rnd_valid), 32'h1);
    chk("bp_next_data",  32'(rnd_data), 32'hA5);

    // enable drop after 5 bits, then a clean 8'h3C
    do_reset();
    en = 1'b1;
    feed(8'h1F, 5, 1'b0);
    repeat (3) @(negedge clk);
    chk("drop_run", 32'(osc_t), 32'h1);
    en = 1'b0;
    @(negedge clk);
    chk("drop_ctrl", 32'({osc_t, osc_i1, osc_i2}), 32'h0);
    repeat (2) @(negedge clk);
    chk("drop_valid", 32'(rnd_valid), 32'h0);
    en = 1'b1;
    feed(8'h3C, 8, 1'b0);
    repeat (2) @(negedge clk);
    chk("reen_valid", 32'(rnd_valid), 32'h1);
    chk("reen_data",  32'(rnd_data), 32'h3C);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
